// File: rtl/sorted_stream_drain.sv
// Drain stage for the insertion sorter: snapshots SIZE sorted words on load and streams the first n = min(count, SIZE) of them over valid/ready.
// Optional build macro SORTED_DRAIN_REVERSE_EN drains from index n-1 down to index 0.
module sorted_stream_drain #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 32,
    parameter int CW    = 5,
    parameter int IW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [CW-1:0]         count,
    input  logic [SIZE*WIDTH-1:0] sorted_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [IW-1:0]         out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } state_t;

    localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
    localparam logic [IW:0]   ONE_N  = (IW+1)'(1);
    localparam logic [IW:0]   TWO_N  = (IW+1)'(2);
    localparam logic [IW-1:0] ONE_I  = IW'(1);

    state_t             state_r;
    state_t             state_nxt;
    logic [WIDTH-1:0]   snap_r [SIZE];
    logic               snap_load_s;
    logic [IW:0]        left_r;
    logic [IW:0]        left_nxt;
    logic               out_valid_r;
    logic               out_valid_nxt;
    logic [WIDTH-1:0]   out_data_r;
    logic [WIDTH-1:0]   out_data_nxt;
    logic [IW-1:0]      out_index_r;
    logic [IW-1:0]      out_index_nxt;
    logic               out_last_r;
    logic               out_last_nxt;
    logic               busy_r;
    logic               busy_nxt;
    logic               done_r;
    logic               done_nxt;
    logic [CW-1:0]      clamp_s;
    logic [IW:0]        n_s;
    logic [IW:0]        n_m1_s;
    logic [IW-1:0]      first_idx_s;
    logic [IW-1:0]      step_idx_s;

    function automatic logic [WIDTH-1:0] entry_of(input logic [SIZE*WIDTH-1:0] flat,
                                                  input logic [IW-1:0]         k);
        return flat[k*WIDTH +: WIDTH];
    endfunction

    // Clamp the requested length and derive the first index and the per-beat index step.
    always_comb begin
        if (count > SIZE_C) begin
            clamp_s = SIZE_C;
        end else begin
            clamp_s = count;
        end
        n_s    = (IW+1)'(clamp_s);
        n_m1_s = n_s - ONE_N;
`ifdef SORTED_DRAIN_REVERSE_EN
        first_idx_s = n_m1_s[IW-1:0];
        step_idx_s  = out_index_r - ONE_I;
`else
        first_idx_s = IW'(0);
        step_idx_s  = out_index_r + ONE_I;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next state and next registered outputs; FIN accepts load exactly like IDLE.
    always_comb begin
        state_nxt     = state_r;
        snap_load_s   = 1'b0;
        left_nxt      = left_r;
        out_valid_nxt = out_valid_r;
        out_data_nxt  = out_data_r;
        out_index_nxt = out_index_r;
        out_last_nxt  = out_last_r;
        busy_nxt      = busy_r;
        done_nxt      = 1'b0;
        case (state_r)
            IDLE, FIN: begin
                if (load) begin
                    snap_load_s = 1'b1;
                    if (n_s != '0) begin
                        state_nxt     = STREAM;
                        left_nxt      = n_s;
                        out_valid_nxt = 1'b1;
                        out_index_nxt = first_idx_s;
                        out_data_nxt  = entry_of(sorted_data, first_idx_s);
                        out_last_nxt  = (n_s == ONE_N);
                        busy_nxt      = 1'b1;
                    end else begin
                        state_nxt     = FIN;
                        left_nxt      = '0;
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        busy_nxt      = 1'b0;
                        done_nxt      = 1'b1;
                    end
                end else begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                    out_last_nxt  = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end
            STREAM: begin
                // A stalled beat keeps every output register unchanged.
                if (out_valid_r && out_ready) begin
                    if (left_r == ONE_N) begin
                        state_nxt     = FIN;
                        left_nxt      = '0;
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                        busy_nxt      = 1'b0;
                        done_nxt      = 1'b1;
                    end else begin
                        left_nxt      = left_r - ONE_N;
                        out_index_nxt = step_idx_s;
                        out_data_nxt  = snap_r[step_idx_s];
                        out_last_nxt  = (left_r == TWO_N);
                    end
                end else begin
                    state_nxt = STREAM;
                end
            end
            default: begin
                state_nxt     = IDLE;
                left_nxt      = '0;
                out_valid_nxt = 1'b0;
                out_data_nxt  = '0;
                out_index_nxt = '0;
                out_last_nxt  = 1'b0;
                busy_nxt      = 1'b0;
            end
        endcase
    end

    // Output and beat-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_r      <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_index_r <= '0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            left_r      <= left_nxt;
            out_valid_r <= out_valid_nxt;
            out_data_r  <= out_data_nxt;
            out_index_r <= out_index_nxt;
            out_last_r  <= out_last_nxt;
            busy_r      <= busy_nxt;
            done_r      <= done_nxt;
        end
    end

    // Snapshot store; only an accepted load samples sorted_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SIZE; k++) begin
                snap_r[k] <= '0;
            end
        end else if (snap_load_s) begin
            for (int k = 0; k < SIZE; k++) begin
                snap_r[k] <= sorted_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_index = out_index_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: doc/sorted_stream_drain.md
Name: sorted_stream_drain

Overview:
- Reader end of the insertion sorting array: snapshots the SIZE parallel sorted words on a load strobe, then emits them one per beat on a valid/ready stream.
- Sits downstream of the sorting array's registered outputs, feeding serial consumers such as a FIFO, UART framer or DMA writer.
- Emits only the first `count` entries, so a partially filled array drains correctly.

Parameters:
- SIZE, 16, number of sorted entries in the snapshot.
- WIDTH, 32, bits per entry.
- CW, 5, width of count; must satisfy 2^CW > SIZE.
- IW, 4, width of out_index; must satisfy 2^IW >= SIZE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low: asserted when 0.
- load  in  1  snapshot strobe, sampled on the clk rising edge.
- count  in  CW  number of valid entries to drain; sampled with load.
- sorted_data  in  SIZE*WIDTH  flattened array; entry k is at bits [k*WIDTH +: WIDTH], entry 0 = first sorter output.
- out_ready  in  1  consumer ready.
- out_valid  out  1  out_data is valid.
- out_data  out  WIDTH  current entry.
- out_index  out  IW  array index of the current entry.
- out_last  out  1  current beat is the final beat.
- busy  out  1  a snapshot is being drained.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (rst=0, async): state IDLE. out_valid, out_last, busy and done = 0. out_data, out_index and the snapshot registers = 0.
- FSM states:
  - IDLE: out_valid=0, busy=0.
  - STREAM: busy=1.
  - FIN: done=1, busy=0.
- IDLE, load=1:
  - Register all SIZE entries from sorted_data and n = min(count, SIZE).
  - If n > 0: go to STREAM. The first beat presents out_valid=1 in the cycle after load (latency 1).
  - If n = 0: go to FIN; no beats are emitted.
- STREAM:
  - Beat j presents snapshot[j] and out_index=j, for j = 0..n-1.
  - out_last = 1 only on beat n-1.
  - A beat transfers on a rising edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_index and out_last are held stable.
  - out_valid is never deasserted mid-stream before the transfer.
  - Back-to-back transfers are supported: one beat per cycle when out_ready is held high.
  - When the last beat transfers, go to FIN.
- FIN: lasts exactly one cycle (done=1, out_valid=0), then IDLE.
  - load is also accepted in FIN, with the same action as IDLE, so a new snapshot can begin immediately.
- load while in STREAM is ignored. The snapshot is not disturbed and no error is flagged.
- The snapshot is isolated from later changes on sorted_data; only load samples the input.
- count > SIZE is clamped to SIZE.
- Reset asserted mid-stream aborts immediately to reset values. No done pulse is produced.
- Internal counter is IW+1 bits wide; no wrap-around is possible within a drain.

Optional Feature:
- Macro: SORTED_DRAIN_REVERSE_EN.
- Defined: entries are drained in reverse order, index n-1 first down to index 0. out_index reflects the true array index, and out_last is asserted on index 0. All handshake, timing and n=0 behaviour is unchanged.
- Undefined: forward order as described in Behaviour.

Test Plan:
- Full forward drain: load=1, count=16, entry k=100+k, out_ready held 1 -> 16 consecutive beats from the cycle after load; out_data=100..115, out_index=0..15; out_last only on the index-15 beat; done pulses the cycle after the last beat.
- Backpressure: count=3, entries 7,9,11; out_ready toggles 1,0,0,1,0,1 -> out_data held stable while stalled; exactly 3 transfers (7,9,11); out_last on the 11 beat.
- Empty and clamp:
  - count=0 -> no out_valid, done pulses 1 cycle after load.
  - count=20 -> exactly 16 beats.
- Snapshot isolation and ignored load: during a count=4 drain, change sorted_data to all 0xFFFFFFFF and pulse load -> the original 4 values are emitted and the drain length is unaffected.
- Reset mid-stream: drop rst to 0 after beat 2 of 16 -> out_valid, busy and done go 0 asynchronously; after release with no load, outputs stay idle.
- Reverse (SORTED_DRAIN_REVERSE_EN defined): count=4, entries 1,2,3,4 -> out_data=4,3,2,1 with out_index=3,2,1,0; out_last on index 0.
